// File: rtl/mutex_trans_pkg.sv
// Shared types and width helpers for the mutex transactor arbiter slice.
// Imported by the interface, the arbiter and the top.
package mutex_trans_pkg;

  typedef enum logic [2:0] {
    ST_CLEAR,
    ST_IDLE,
    ST_GRANT,
    ST_WORK,
    ST_DONE
  } state_t;

  localparam int DEF_NUM_CHAN = 4;
  localparam int DEF_OP_W     = 11;
  localparam int DEF_DEPTH    = 1256;

  // Never returns 0 so that single-entry ranges still get a 1-bit index.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  localparam int DEF_IDX_W  = clog2_min1(DEF_NUM_CHAN);
  localparam int DEF_ADDR_W = clog2_min1(DEF_DEPTH);

endpackage

// File: rtl/mutex_trans_arb_if.sv
// Requester-side handshake bundle: level requests with per-channel op codes,
// per-channel done pulses and the shared engine busy flag.
interface mutex_trans_arb_if
  import mutex_trans_pkg::*;
#(
  parameter int NUM_CHAN = DEF_NUM_CHAN,
  parameter int OP_W     = DEF_OP_W
);
  logic [NUM_CHAN-1:0]      req;
  logic [NUM_CHAN*OP_W-1:0] op_code;
  logic [NUM_CHAN-1:0]      done;
  logic                     busy;

  modport master (output req, output op_code, input done, input busy);
  modport slave  (input req, input op_code, output done, output busy);
endinterface

// File: rtl/mutex_trans_arb_rr_arbiter.sv
// Combinational round-robin picker: first requesting channel at or after ptr,
// wrapping around modulo NUM_CHAN.
module rr_arbiter
  import mutex_trans_pkg::*;
#(
  parameter int NUM_CHAN = DEF_NUM_CHAN,
  parameter int IW       = clog2_min1(NUM_CHAN)
) (
  input  logic [NUM_CHAN-1:0] req,
  input  logic [IW-1:0]       ptr,
  output logic [NUM_CHAN-1:0] gnt,
  output logic [IW-1:0]       idx,
  output logic                valid
);

  int c;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    valid = 1'b0;
    c     = 0;
    for (int i = 0; i < NUM_CHAN; i++) begin
      c = (int'(ptr) + i) % NUM_CHAN;
      if (!valid && req[c]) begin
        valid  = 1'b1;
        gnt[c] = 1'b1;
        idx    = IW'(c);
      end
    end
  end

endmodule

// File: rtl/mutex_trans_arb.sv
// Shared op-code counting engine: one round-robin grant at a time, a per-op
// totals memory swept to zero after reset or clear, and a registered read port.
module mutex_trans_arb
  import mutex_trans_pkg::*;
#(
  parameter int NUM_CHAN    = DEF_NUM_CHAN,
  parameter int OP_W        = DEF_OP_W,
  parameter int DEPTH       = DEF_DEPTH,
  parameter int CNT_W       = 32,
  parameter int BUSY_CYCLES = 1,
  parameter int SATURATE    = 0
) (
  input  logic                clk,
  input  logic                reset_n,
  mutex_trans_arb_if.slave    bus,
  input  logic                clear,
  output logic                clear_busy,
  input  logic [OP_W-1:0]     rd_addr,
  output logic [CNT_W-1:0]    rd_data,
  output logic                err_op,
  output logic [CNT_W-1:0]    total_grants
);

  localparam int AW = clog2_min1(DEPTH);
  localparam int IW = clog2_min1(NUM_CHAN);
  localparam int BW = clog2_min1(BUSY_CYCLES);
  localparam logic [AW-1:0] CLR_LAST  = AW'(DEPTH - 1);
  localparam logic [BW-1:0] BUSY_LAST = BW'(BUSY_CYCLES - 1);
  localparam logic [IW-1:0] CHAN_LAST = IW'(NUM_CHAN - 1);

  function automatic logic addr_ok(input logic [OP_W-1:0] a);
    return 32'(a) < DEPTH;
  endfunction

  function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] v);
    if (SATURATE != 0 && v == '1) return v;
    return v + 1'b1;
  endfunction

  state_t state, next_state;

  logic [NUM_CHAN-1:0] arb_gnt, grant_oh;
  logic [IW-1:0]       arb_idx, grant_idx, ptr;
  logic                arb_valid;
  logic [OP_W-1:0]     sel_op, grant_op;
  logic [BW-1:0]       busy_cnt;
  logic [AW-1:0]       clr_addr;
  logic                clear_pend, op_ok;
  logic [CNT_W-1:0]    mem [DEPTH];
  logic [CNT_W-1:0]    old_val, mem_wdata;
  logic [AW-1:0]       mem_waddr;
  logic                mem_we;

  rr_arbiter #(.NUM_CHAN(NUM_CHAN), .IW(IW)) u_arb (
    .req   (bus.req),
    .ptr   (ptr),
    .gnt   (arb_gnt),
    .idx   (arb_idx),
    .valid (arb_valid)
  );

  assign sel_op     = bus.op_code[int'(arb_idx)*OP_W +: OP_W];
  assign op_ok      = addr_ok(grant_op);
  assign clear_busy = (state == ST_CLEAR);
  assign bus.busy   = state inside {ST_GRANT, ST_WORK, ST_DONE};
  assign bus.done   = (state == ST_DONE) ? grant_oh : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_CLEAR;
    else          state <= next_state;
  end

  // A pending clear beats any waiting request; a clear inside the sweep restarts it.
  always_comb begin
    next_state = state;
    unique case (state)
      ST_CLEAR: if (!clear && clr_addr == CLR_LAST) next_state = ST_IDLE;
      ST_IDLE: begin
        if (clear || clear_pend) next_state = ST_CLEAR;
        else if (arb_valid)      next_state = ST_GRANT;
      end
      ST_GRANT: next_state = ST_WORK;
      ST_WORK:  if (busy_cnt == BUSY_LAST) next_state = ST_DONE;
      ST_DONE:  next_state = ST_IDLE;
      default:  next_state = ST_CLEAR;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clr_addr     <= '0;
      clear_pend   <= 1'b0;
      ptr          <= '0;
      grant_idx    <= '0;
      grant_oh     <= '0;
      grant_op     <= '0;
      busy_cnt     <= '0;
      err_op       <= 1'b0;
      total_grants <= '0;
    end else begin
      unique case (state)
        ST_CLEAR: begin
          clear_pend   <= 1'b0;
          err_op       <= 1'b0;
          total_grants <= '0;
          clr_addr     <= (clear || clr_addr == CLR_LAST) ? '0 : clr_addr + 1'b1;
        end
        ST_IDLE: begin
          if (!(clear || clear_pend) && arb_valid) begin
            grant_idx <= arb_idx;
            grant_oh  <= arb_gnt;
            grant_op  <= sel_op;
          end
        end
        ST_GRANT: begin
          busy_cnt <= '0;
          if (!op_ok) err_op <= 1'b1;
          if (clear) clear_pend <= 1'b1;
        end
        ST_WORK: begin
          if (busy_cnt != BUSY_LAST) busy_cnt <= busy_cnt + 1'b1;
          if (clear) clear_pend <= 1'b1;
        end
        ST_DONE: begin
          total_grants <= total_grants + 1'b1;
          ptr          <= (grant_idx == CHAN_LAST) ? '0 : grant_idx + 1'b1;
          if (clear) clear_pend <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // The increment lands on the first WORK edge; later WORK cycles only stretch busy.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = clr_addr;
    mem_wdata = '0;
    if (state == ST_CLEAR) begin
      mem_we = 1'b1;
    end else if (state == ST_WORK && busy_cnt == '0 && op_ok) begin
      mem_we    = 1'b1;
      mem_waddr = grant_op[AW-1:0];
      mem_wdata = bump(old_val);
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
    if (state == ST_GRANT && op_ok) old_val <= mem[grant_op[AW-1:0]];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)              rd_data <= '0;
    else if (addr_ok(rd_addr)) rd_data <= mem[rd_addr[AW-1:0]];
    else                       rd_data <= '0;
  end

endmodule

// File: doc/mutex_trans_arb.md
Name: mutex_trans_arb

Overview:
- Clocked, parametrised successor to the op-code counting test transactor.
- NUM_CHAN requesters share one transactor engine under mutual exclusion.
- A round-robin arbiter grants one channel at a time. The engine increments a per-op-code total, holds for a programmable busy time, then pulses done to the granted channel.
- Sits in Teal mutex/thread-contention tests; totals are read back through a registered read port.

Parameters:
- NUM_CHAN, 4, number of requesting channels (2..16)
- OP_W, 11, op_code width
- DEPTH, 1256, number of totals entries; valid op_code range is 0..DEPTH-1
- CNT_W, 32, width of each total and of total_grants
- BUSY_CYCLES, 1, WORK state duration in cycles (>=1)
- SATURATE, 0, 0 = totals wrap modulo 2^CNT_W; 1 = totals hold at all-ones

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- req  in  NUM_CHAN  level request per channel; held until that channel's done
- op_code  in  NUM_CHAN*OP_W  channel i op code at bits [i*OP_W +: OP_W]; stable while req[i]=1
- done  out  NUM_CHAN  one-cycle completion pulse to the granted channel
- busy  out  1  high in GRANT, WORK and DONE
- clear  in  1  single-cycle pulse; zeroes all totals, err_op and total_grants
- clear_busy  out  1  high while the CLEAR sweep runs
- rd_addr  in  OP_W  totals read address
- rd_data  out  CNT_W  totals[rd_addr], registered, 1-cycle latency
- err_op  out  1  sticky; set when a granted op_code is >= DEPTH
- total_grants  out  CNT_W  count of completed grants; wraps

Behaviour:
- Reset (async assert): done=0, busy=0, err_op=0, total_grants=0, rd_data=0, rr pointer=0, state=CLEAR, clear_busy=1.
- Totals memory is not reset directly. The CLEAR state writes 0 to addresses 0..DEPTH-1, one per cycle, then enters IDLE. clear_busy drops with the IDLE entry.
- States:
  - IDLE: if clear is pending, go to CLEAR. Otherwise, if any req is set, the arbiter picks the first requesting channel at or after the rr pointer. Latch grant id and op_code; go to GRANT.
  - GRANT: read totals[op]; go to WORK.
  - WORK: write the increment at the first WORK edge. Stay BUSY_CYCLES cycles total.
  - DONE: done[grant]=1 for exactly one cycle; total_grants+1; rr pointer = grant+1 mod NUM_CHAN; go to IDLE.
- Latency: req sampled at edge 0 -> GRANT in cycle 1 -> WORK in cycles 2..1+BUSY_CYCLES -> done in cycle 2+BUSY_CYCLES. Minimum service period per grant is 3+BUSY_CYCLES cycles.
- Requester contract: drop req on the edge where done is seen. Arbitration happens in IDLE, so a completed channel is never double-granted. If a channel keeps req high, it is re-granted only after the other channels per round-robin order.
- Out-of-range op_code (>= DEPTH): no memory write; err_op set; done still pulses; total_grants still increments.
- Arithmetic: SATURATE=0 gives all-ones+1 -> 0. SATURATE=1 gives all-ones stays all-ones.
- Read port:
  - Read-first: if rd_addr equals the entry written the same cycle, rd_data returns the old value.
  - rd_addr >= DEPTH returns 0.
  - Reads during CLEAR return 0 for swept entries and are otherwise don't-care.
- clear during GRANT/WORK/DONE: latched pending. The current grant completes, including its done pulse, then IDLE goes straight to CLEAR.
- clear vs req in IDLE: clear wins; the requests wait.
- clear during CLEAR: restarts the sweep at address 0.
- Reset mid-WORK: the in-flight grant is abandoned with no done pulse. Requesters re-request after reset.

Decomposition:
- Package mutex_trans_pkg: state enum (CLEAR, IDLE, GRANT, WORK, DONE) and width helper constants (clog2 of DEPTH and NUM_CHAN).
- Sub-module rr_arbiter: NUM_CHAN-wide request vector plus pointer in; one-hot grant and index out; purely combinational.
- Top holds the FSM, totals memory, counters and read port.

Test Plan:
- Reset then idle: reset_n low 3 cycles -> clear_busy high exactly DEPTH=1256 cycles; afterwards rd_addr=0..1255 all read 0; done=0 throughout.
- Single request: ch0 req, op_code=5, BUSY_CYCLES=1 -> done[0] pulses exactly 3 cycles after sampling; totals[5]=1; total_grants=1.
- Contention: all 4 channels request at once with op_codes 1,2,3,4, each re-requesting 3 times -> grant order 0,1,2,3 repeating; totals[1..4]=3 each; total_grants=12; done never on two channels at once.
- Boundary op and wrap:
  - op_code=1256 -> err_op=1, no totals change, done still pulses.
  - With CNT_W=4, SATURATE=0: 16 grants of op 7 -> totals[7]=0.
  - With SATURATE=1: 16 grants of op 7 -> totals[7]=15.
- Clear mid-work: clear pulses in WORK of ch2, op 9 -> done[2] still pulses, then clear_busy rises next cycle; after the sweep, totals[9]=0, err_op=0, total_grants=0.
- Reset mid-work: reset_n low during WORK, ch1 op 3 -> no done[1]; after the sweep, totals[3]=0; re-request completes normally.
